// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the rvc_asap memory-access path.
package rvc_asap_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } t_mem_size;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } t_split_state;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Encoding 2'b11 is not a legal size and is handled as a word access.
  function automatic t_mem_size decode_size(input logic [1:0] raw);
    return (raw == 2'b11) ? WORD : t_mem_size'(raw);
  endfunction

  function automatic logic [3:0] size_mask(input t_mem_size sz);
    case (sz)
      BYTE:    return MASK_BYTE;
      HALF:    return MASK_HALF;
      default: return MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/rvc_asap_5pl_load_align.sv
// Selects the addressed bytes from up to two read words and extends them
// to a 32-bit load result.
module rvc_asap_5pl_load_align
  import rvc_asap_pkg::*;
(
  input  logic [63:0] raw_i,
  input  logic [1:0]  offset_i,
  input  t_mem_size   size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] win;
  logic        unused_raw_hi;

  always_comb begin
    case (offset_i)
      2'd0:    win = raw_i[31:0];
      2'd1:    win = raw_i[39:8];
      2'd2:    win = raw_i[47:16];
      default: win = raw_i[55:24];
    endcase
    case (size_i)
      BYTE:    data_o = {{24{sign_i & win[7]}}, win[7:0]};
      HALF:    data_o = {{16{sign_i & win[15]}}, win[15:0]};
      default: data_o = win;
    endcase
  end

  // The top byte can never fall inside a 4-byte window starting at offset <= 3.
  assign unused_raw_hi = ^raw_i[63:56];

endmodule

// File: rtl/rvc_asap_5pl_mem_access.sv
// Core-to-memory-wrapper access unit. With RVC_MISALIGN_SPLIT_EN defined,
// word-crossing accesses are split in two; otherwise they are rejected.
module rvc_asap_5pl_mem_access
  import rvc_asap_pkg::*;
(
  input  logic        Clock,
  input  logic        Rst,
  input  logic        DMemWrEnQ103H,
  input  logic        DMemRdEnQ103H,
  input  logic [31:0] DMemAddressQ103H,
  input  logic [31:0] DMemWrDataQ103H,
  input  logic [1:0]  DMemSizeQ103H,
  input  logic        DMemSignExtQ103H,
  output logic        StallQ103H,
  output logic        MisalignErrQ103H,
  output logic [31:0] LoadDataQ104H,
  output logic [31:0] data,
  output logic [31:0] address,
  output logic [3:0]  byteena,
  output logic        wren,
  output logic        rden,
  input  logic [31:0] q
);

  t_mem_size   size;
  logic [1:0]  offset;
  logic [7:0]  mask_sh;
  logic [63:0] data_sh;
  logic [31:0] base_addr;
  logic        req;
  logic        crossing;

  logic        second;
  logic        stall_c;
  logic        misalign_c;
  logic        issue_c;
  logic [31:0] first_word;

  always_comb begin
    size      = decode_size(DMemSizeQ103H);
    offset    = DMemAddressQ103H[1:0];
    mask_sh   = {4'b0000, size_mask(size)} << offset;
    data_sh   = {32'h0, DMemWrDataQ103H} << {offset, 3'b000};
    base_addr = {DMemAddressQ103H[31:2], 2'b00};
    req       = DMemWrEnQ103H | DMemRdEnQ103H;
    crossing  = req && (((size == HALF) && (offset == 2'd3)) ||
                        ((size == WORD) && (offset != 2'd0)));
  end

`ifdef RVC_MISALIGN_SPLIT_EN
  t_split_state state_q, state_d;
  logic [31:0]  first_rd_data_q, first_rd_data_d;

  always_comb begin
    second          = (state_q == S_SECOND);
    stall_c         = crossing & ~second;
    misalign_c      = 1'b0;
    issue_c         = req;
    state_d         = S_IDLE;
    first_rd_data_d = second ? q : first_rd_data_q;
    if (!Rst && !second && crossing) state_d = S_SECOND;
    if (Rst) first_rd_data_d = '0;
  end

  always_ff @(posedge Clock) begin
    state_q         <= state_d;
    first_rd_data_q <= first_rd_data_d;
  end

  assign first_word = first_rd_data_q;
`else
  always_comb begin
    second     = 1'b0;
    stall_c    = 1'b0;
    misalign_c = crossing;
    issue_c    = req & ~crossing;
  end

  assign first_word = '0;
`endif

  // The second half of a split reuses the held request: upper lanes, next word.
  always_comb begin
    wren             = issue_c & DMemWrEnQ103H & ~Rst;
    rden             = issue_c & DMemRdEnQ103H & ~DMemWrEnQ103H & ~Rst;
    StallQ103H       = stall_c & ~Rst;
    MisalignErrQ103H = misalign_c & ~Rst;
    address          = second ? (base_addr + 32'd4) : base_addr;
    data             = second ? data_sh[63:32] : data_sh[31:0];
    byteena          = '0;
    if (wren | rden) byteena = second ? mask_sh[7:4] : mask_sh[3:0];
  end

  t_mem_size  ld_size_q, ld_size_d;
  logic       ld_sign_q, ld_sign_d;
  logic [1:0] ld_offset_q, ld_offset_d;
  logic       ld_split_q, ld_split_d;
  logic       ld_valid_q, ld_valid_d;

  // A split load only becomes a Q104H result after its second access.
  always_comb begin
    ld_valid_d  = rden & ~StallQ103H;
    ld_size_d   = size;
    ld_sign_d   = DMemSignExtQ103H;
    ld_offset_d = offset;
    ld_split_d  = second;
    if (Rst) begin
      ld_valid_d  = 1'b0;
      ld_size_d   = BYTE;
      ld_sign_d   = 1'b0;
      ld_offset_d = '0;
      ld_split_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    ld_valid_q  <= ld_valid_d;
    ld_size_q   <= ld_size_d;
    ld_sign_q   <= ld_sign_d;
    ld_offset_q <= ld_offset_d;
    ld_split_q  <= ld_split_d;
  end

  logic [63:0] raw64;
  logic [31:0] aligned;

  assign raw64 = ld_split_q ? {q, first_word} : {32'h0, q};

  rvc_asap_5pl_load_align u_load_align (
    .raw_i    (raw64),
    .offset_i (ld_offset_q),
    .size_i   (ld_size_q),
    .sign_i   (ld_sign_q),
    .data_o   (aligned)
  );

  assign LoadDataQ104H = ld_valid_q ? aligned : '0;

endmodule

// File: tb/tb_rvc_asap_5pl_mem_access.sv
// Directed, table-driven bench for rvc_asap_5pl_mem_access with a small
// byte-lane memory standing in for the wrapper.
module tb_rvc_asap_5pl_mem_access;

  logic        Clock;
  logic        Rst;
  logic        DMemWrEnQ103H;
  logic        DMemRdEnQ103H;
  logic [31:0] DMemAddressQ103H;
  logic [31:0] DMemWrDataQ103H;
  logic [1:0]  DMemSizeQ103H;
  logic        DMemSignExtQ103H;
  logic        StallQ103H;
  logic        MisalignErrQ103H;
  logic [31:0] LoadDataQ104H;
  logic [31:0] data;
  logic [31:0] address;
  logic [3:0]  byteena;
  logic        wren;
  logic        rden;
  logic [31:0] q;

  int n_cmp = 0;
  int n_fail = 0;

  rvc_asap_5pl_mem_access dut (
    .Clock            (Clock),
    .Rst              (Rst),
    .DMemWrEnQ103H    (DMemWrEnQ103H),
    .DMemRdEnQ103H    (DMemRdEnQ103H),
    .DMemAddressQ103H (DMemAddressQ103H),
    .DMemWrDataQ103H  (DMemWrDataQ103H),
    .DMemSizeQ103H    (DMemSizeQ103H),
    .DMemSignExtQ103H (DMemSignExtQ103H),
    .StallQ103H       (StallQ103H),
    .MisalignErrQ103H (MisalignErrQ103H),
    .LoadDataQ104H    (LoadDataQ104H),
    .data             (data),
    .address          (address),
    .byteena          (byteena),
    .wren             (wren),
    .rden             (rden),
    .q                (q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Wrapper model: 64 words, byte-enabled writes, read data one cycle later.
  logic [31:0] mem [64];
  always @(posedge Clock) begin
    if (wren)
      for (int i = 0; i < 4; i++)
        if (byteena[i]) mem[address[7:2]][8*i +: 8] <= data[8*i +: 8];
    if (rden) q <= mem[address[7:2]];
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_data;
    logic        e_wren;
    logic        e_rden;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ed,
                              input logic ewr, input logic erd, input logic [31:0] eld);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.size = sz; v.sign = sg;
    v.e_addr = ea; v.e_be = ebe; v.e_data = ed; v.e_wren = ewr; v.e_rden = erd; v.e_load = eld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic sg);
    DMemWrEnQ103H    = wr;
    DMemRdEnQ103H    = rd;
    DMemAddressQ103H = a;
    DMemWrDataQ103H  = wd;
    DMemSizeQ103H    = sz;
    DMemSignExtQ103H = sg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic next_cyc();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 32'h1000, 32'h12345678, 2'd2, 0, 32'h1000, 4'b1111, 32'h12345678, 1, 0, 32'h0);
    vecs[1]  = mk(0, 1, 32'h1000, 32'h0,        2'd2, 0, 32'h1000, 4'b1111, 32'h0,        0, 1, 32'h12345678);
    vecs[2]  = mk(1, 0, 32'h1003, 32'h00000080, 2'd0, 0, 32'h1000, 4'b1000, 32'h80000000, 1, 0, 32'h0);
    vecs[3]  = mk(0, 1, 32'h1003, 32'h0,        2'd0, 1, 32'h1000, 4'b1000, 32'h0,        0, 1, 32'hFFFFFF80);
    vecs[4]  = mk(0, 1, 32'h1003, 32'h0,        2'd0, 0, 32'h1000, 4'b1000, 32'h0,        0, 1, 32'h00000080);
    vecs[5]  = mk(1, 0, 32'h1005, 32'h0000BEEF, 2'd1, 0, 32'h1004, 4'b0110, 32'h00BEEF00, 1, 0, 32'h0);
    vecs[6]  = mk(0, 1, 32'h1005, 32'h0,        2'd1, 1, 32'h1004, 4'b0110, 32'h0,        0, 1, 32'hFFFFBEEF);
    vecs[7]  = mk(0, 1, 32'h1005, 32'h0,        2'd1, 0, 32'h1004, 4'b0110, 32'h0,        0, 1, 32'h0000BEEF);
    vecs[8]  = mk(1, 1, 32'h1008, 32'hCAFEF00D, 2'd2, 1, 32'h1008, 4'b1111, 32'hCAFEF00D, 1, 0, 32'h0);
    vecs[9]  = mk(0, 1, 32'h1008, 32'h0,        2'd2, 0, 32'h1008, 4'b1111, 32'h0,        0, 1, 32'hCAFEF00D);
    vecs[10] = mk(0, 1, 32'h100A, 32'h0,        2'd0, 1, 32'h1008, 4'b0100, 32'h0,        0, 1, 32'hFFFFFFFE);
    vecs[11] = mk(1, 0, 32'h100C, 32'h01020304, 2'd3, 0, 32'h100C, 4'b1111, 32'h01020304, 1, 0, 32'h0);
    vecs[12] = mk(0, 1, 32'h100E, 32'h0,        2'd1, 0, 32'h100C, 4'b1100, 32'h0,        0, 1, 32'h00000102);
    vecs[13] = mk(0, 1, 32'h1009, 32'h0,        2'd1, 1, 32'h1008, 4'b0110, 32'h0,        0, 1, 32'hFFFFFEF0);

    // Reset: a pending store must not reach the wrapper.
    Rst = 1'b1;
    drive(1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 2'd2, 1'b0);
    @(negedge Clock);
    chk("rst_wren", wren, 0);
    chk("rst_rden", rden, 0);
    chk("rst_stall", StallQ103H, 0);
    chk("rst_err", MisalignErrQ103H, 0);
    chk("rst_byteena", byteena, 0);
    next_cyc();
    Rst = 1'b0;
    idle();
    @(negedge Clock);
    chk("rst_load", LoadDataQ104H, 0);
    chk("rst_stall_after", StallQ103H, 0);

    for (int i = 0; i < 14; i++) begin
      next_cyc();
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign);
      @(negedge Clock);
      chk($sformatf("v%0d_address", i), address, vecs[i].e_addr);
      chk($sformatf("v%0d_byteena", i), byteena, vecs[i].e_be);
      chk($sformatf("v%0d_data", i), data, vecs[i].e_data);
      chk($sformatf("v%0d_wren", i), wren, vecs[i].e_wren);
      chk($sformatf("v%0d_rden", i), rden, vecs[i].e_rden);
      chk($sformatf("v%0d_stall", i), StallQ103H, 0);
      chk($sformatf("v%0d_err", i), MisalignErrQ103H, 0);
      next_cyc();
      idle();
      @(negedge Clock);
      chk($sformatf("v%0d_load", i), LoadDataQ104H, vecs[i].e_load);
    end

`ifdef RVC_MISALIGN_SPLIT_EN
    // Crossing word store 0xAABBCCDD at 0x1002.
    next_cyc();
    drive(1'b1, 1'b0, 32'h1002, 32'hAABBCCDD, 2'd2, 1'b0);
    @(negedge Clock);
    chk("sw1_address", address, 32'h1000);
    chk("sw1_byteena", byteena, 4'b1100);
    chk("sw1_data", data, 32'hCCDD0000);
    chk("sw1_stall", StallQ103H, 1);
    chk("sw1_wren", wren, 1);
    next_cyc();
    @(negedge Clock);
    chk("sw2_address", address, 32'h1004);
    chk("sw2_byteena", byteena, 4'b0011);
    chk("sw2_data", data, 32'h0000AABB);
    chk("sw2_stall", StallQ103H, 0);
    chk("sw2_wren", wren, 1);

    // Crossing word load back from 0x1002.
    next_cyc();
    drive(1'b0, 1'b1, 32'h1002, 32'h0, 2'd2, 1'b0);
    @(negedge Clock);
    chk("lw1_stall", StallQ103H, 1);
    chk("lw1_rden", rden, 1);
    chk("lw1_load_none", LoadDataQ104H, 0);
    next_cyc();
    @(negedge Clock);
    chk("lw2_address", address, 32'h1004);
    chk("lw2_stall", StallQ103H, 0);
    next_cyc();
    idle();
    @(negedge Clock);
    chk("lw_result", LoadDataQ104H, 32'hAABBCCDD);

    // Place 0x34 at 0x1007 and 0xF2 at 0x1008.
    next_cyc();
    drive(1'b1, 1'b0, 32'h1007, 32'h34, 2'd0, 1'b0);
    @(negedge Clock);
    chk("sb34_data", data, 32'h34000000);
    next_cyc();
    drive(1'b1, 1'b0, 32'h1008, 32'hF2, 2'd0, 1'b0);
    @(negedge Clock);
    chk("sbf2_byteena", byteena, 4'b0001);

    // Back-to-back crossing signed half loads at 0x1007.
    next_cyc();
    drive(1'b0, 1'b1, 32'h1007, 32'h0, 2'd1, 1'b1);
    @(negedge Clock);
    chk("lh1a_byteena", byteena, 4'b1000);
    chk("lh1a_stall", StallQ103H, 1);
    next_cyc();
    @(negedge Clock);
    chk("lh1b_byteena", byteena, 4'b0001);
    chk("lh1b_address", address, 32'h1008);
    chk("lh1b_stall", StallQ103H, 0);
    next_cyc();
    @(negedge Clock);
    chk("lh2a_stall", StallQ103H, 1);
    chk("lh2a_address", address, 32'h1004);
    chk("lh1_result", LoadDataQ104H, 32'hFFFFF234);
    next_cyc();
    @(negedge Clock);
    chk("lh2b_stall", StallQ103H, 0);
    next_cyc();
    idle();
    @(negedge Clock);
    chk("lh2_result", LoadDataQ104H, 32'hFFFFF234);

    // Reset arriving while the second access is pending.
    next_cyc();
    drive(1'b0, 1'b1, 32'h1002, 32'h0, 2'd2, 1'b0);
    @(negedge Clock);
    chk("rs_first_stall", StallQ103H, 1);
    next_cyc();
    Rst = 1'b1;
    @(negedge Clock);
    chk("rs_wren", wren, 0);
    chk("rs_rden", rden, 0);
    chk("rs_stall", StallQ103H, 0);
    next_cyc();
    Rst = 1'b0;
    drive(1'b0, 1'b1, 32'h1000, 32'h0, 2'd2, 1'b0);
    @(negedge Clock);
    chk("rs_load_cleared", LoadDataQ104H, 0);
    chk("rs_idle_address", address, 32'h1000);
    chk("rs_idle_stall", StallQ103H, 0);
    next_cyc();
    idle();
    @(negedge Clock);
    chk("rs_after_load", LoadDataQ104H, 32'hCCDD5678);

    // Address wrap on a crossing store.
    next_cyc();
    drive(1'b1, 1'b0, 32'hFFFFFFFE, 32'h11223344, 2'd2, 1'b0);
    @(negedge Clock);
    chk("wrap1_address", address, 32'hFFFFFFFC);
    chk("wrap1_byteena", byteena, 4'b1100);
    chk("wrap1_data", data, 32'h33440000);
    chk("wrap1_stall", StallQ103H, 1);
    next_cyc();
    @(negedge Clock);
    chk("wrap2_address", address, 32'h00000000);
    chk("wrap2_byteena", byteena, 4'b0011);
    chk("wrap2_data", data, 32'h00001122);
    chk("wrap2_stall", StallQ103H, 0);
    next_cyc();
    idle();
`else
    // Crossing word load at 0x1001 is rejected.
    next_cyc();
    drive(1'b0, 1'b1, 32'h1001, 32'h0, 2'd2, 1'b0);
    @(negedge Clock);
    chk("rej_err", MisalignErrQ103H, 1);
    chk("rej_rden", rden, 0);
    chk("rej_wren", wren, 0);
    chk("rej_stall", StallQ103H, 0);
    chk("rej_byteena", byteena, 0);
    next_cyc();
    idle();
    @(negedge Clock);
    chk("rej_err_pulse", MisalignErrQ103H, 0);
    chk("rej_load", LoadDataQ104H, 0);

    // Crossing half store at 0x1007 is rejected.
    next_cyc();
    drive(1'b1, 1'b0, 32'h1007, 32'h1234, 2'd1, 1'b0);
    @(negedge Clock);
    chk("rejh_err", MisalignErrQ103H, 1);
    chk("rejh_wren", wren, 0);

    // Crossing store at the top of the address space is rejected too.
    next_cyc();
    drive(1'b1, 1'b0, 32'hFFFFFFFE, 32'h11223344, 2'd2, 1'b0);
    @(negedge Clock);
    chk("rejw_err", MisalignErrQ103H, 1);
    chk("rejw_wren", wren, 0);

    // Non-crossing misaligned half at 0x1002 still proceeds.
    next_cyc();
    drive(1'b0, 1'b1, 32'h1002, 32'h0, 2'd1, 1'b0);
    @(negedge Clock);
    chk("okh_err", MisalignErrQ103H, 0);
    chk("okh_rden", rden, 1);
    chk("okh_byteena", byteena, 4'b1100);
    next_cyc();
    idle();
    @(negedge Clock);
    chk("okh_load", LoadDataQ104H, 32'h00008034);
`endif

    next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
